// File: rtl/axi_read_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_read_slave_mem
// AXI3-style read-channel responder backed by a fixed ROM pattern
// (mem[i] = {16'hA5A5, i[15:0]}, resized to DATA_WIDTH). One AR request is
// accepted at a time; ARLEN+1 R beats are returned after READ_LATENCY idle
// cycles. FIXED/INCR/WRAP bursts are supported. Illegal requests return
// SLVERR on every beat; beats that fall outside the memory return SLVERR
// individually. Error beats carry zero data.
//
// Ports
//   G_clk    in   clock, rising edge
//   G_reset  in   asynchronous active-low reset
//   ARADDR   in   burst start byte address
//   ARLEN    in   beats-1
//   ARSIZE   in   log2(bytes per beat)
//   ARBURST  in   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   ARVALID  in   address valid
//   ARREADY  out  address accept (registered)
//   RDATA    out  read data
//   RRESP    out  00 OKAY, 10 SLVERR
//   RLAST    out  final beat of burst
//   RVALID   out  read data valid
//   RREADY   in   master accepts beat
//
// state  | meaning
// S_IDLE | ARREADY high, waiting for an address handshake
// S_WAIT | read latency countdown after accept
// S_DATA | presenting beats; first cycle loads beat 0 into the R registers
// ---------------------------------------------------------------------------
module axi_read_slave_mem #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  G_clk,
    input  logic                  G_reset,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    burst_err_q, burst_err_d;
    logic [3:0]              beat_cnt_q, beat_cnt_d;
    logic [3:0]              lat_cnt_q, lat_cnt_d;

    // ---------------------------------------------------------------------
    // Request legality, evaluated on the AR inputs at accept time
    // ---------------------------------------------------------------------
    logic                  ar_err;
    logic                  wrap_len_ok;
    logic [ADDR_WIDTH-1:0] ar_size_mask;

    always_comb begin
        wrap_len_ok  = (ARLEN == 4'd1) || (ARLEN == 4'd3) ||
                       (ARLEN == 4'd7) || (ARLEN == 4'd15);
        ar_size_mask = (ADDR_WIDTH'(1) << ARSIZE) - ADDR_WIDTH'(1);
        ar_err       = (ARSIZE > 3'(LOG2_BYTES)) ||
                       (ARBURST == BURST_RSVD) ||
                       ((ARBURST == BURST_WRAP) &&
                        (!wrap_len_ok || ((ARADDR & ar_size_mask) != '0)));
    end

    // ---------------------------------------------------------------------
    // Next beat address
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    always_comb begin
        addr_incr = ADDR_WIDTH'(1) << size_q;
        // Wrap block is (LEN+1)<<SIZE bytes; the mask selects the in-block offset.
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            BURST_INCR: addr_nxt = addr_q + addr_incr;
            BURST_WRAP: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + addr_incr) & wrap_mask);
            default:    addr_nxt = addr_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Beat content for the beat about to be loaded into the R registers.
    // Beat 0 uses the latched start address; later beats use addr_nxt so the
    // following beat is presented on the same edge as the handshake.
    // ---------------------------------------------------------------------
    logic                  advance;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [3:0]            sel_cnt;
    logic                  below_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  beat_err;
    logic [31:0]           word32;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [DATA_WIDTH-1:0] beat_rdata;
    logic [1:0]            beat_rresp;
    logic                  beat_last;

    assign advance = rvalid_q;
    assign sel_addr = advance ? addr_nxt : addr_q;
    assign sel_cnt  = advance ? (beat_cnt_q + 4'd1) : beat_cnt_q;

    // Borrow out of the subtraction flags addresses below BASE_ADDR.
    assign {below_base, offset} = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
    assign word_idx = offset >> LOG2_BYTES;
    assign word32   = {16'hA5A5, word_idx[15:0]};

    generate
        if (DATA_WIDTH > 32) begin : g_wide
            assign mem_word = {{(DATA_WIDTH-32){1'b0}}, word32};
        end else if (DATA_WIDTH == 32) begin : g_exact
            assign mem_word = word32;
        end else begin : g_narrow
            assign mem_word = word32[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        beat_err   = burst_err_q || below_base || (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
        beat_rdata = beat_err ? '0 : mem_word;
        beat_rresp = beat_err ? RESP_SLVERR : RESP_OKAY;
        beat_last  = (sel_cnt == len_q);
    end

    // ---------------------------------------------------------------------
    // FSM next state / outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        burst_err_d = burst_err_q;
        beat_cnt_d  = beat_cnt_q;
        lat_cnt_d   = lat_cnt_q;

        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    arready_d   = 1'b0;
                    addr_d      = ARADDR;
                    len_d       = ARLEN;
                    size_d      = ARSIZE;
                    burst_d     = ARBURST;
                    burst_err_d = ar_err;
                    beat_cnt_d  = 4'd0;
                    lat_cnt_d   = 4'(READ_LATENCY);
                    state_d     = (READ_LATENCY > 0) ? S_WAIT : S_DATA;
                end
            end

            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q <= 4'd1) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = beat_rdata;
                    rresp_d  = beat_rresp;
                    rlast_d  = beat_last;
                end else if (RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = RESP_OKAY;
                        rdata_d   = '0;
                        arready_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        addr_d     = addr_nxt;
                        beat_cnt_d = sel_cnt;
                        rdata_d    = beat_rdata;
                        rresp_d    = beat_rresp;
                        rlast_d    = beat_last;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge G_clk or negedge G_reset) begin
        if (!G_reset) begin
            state_q     <= S_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            burst_err_q <= 1'b0;
            beat_cnt_q  <= '0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            burst_err_q <= burst_err_d;
            beat_cnt_q  <= beat_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_read_slave_mem
// Drives directed and random AR requests into axi_read_slave_mem and compares
// every R beat against a burst model built from address arithmetic.
// ---------------------------------------------------------------------------
module tb_axi_read_slave_mem;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          LAT   = 1;

    logic          G_clk;
    logic          G_reset;
    logic [AW-1:0] ARADDR;
    logic [3:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    axi_read_slave_mem #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (DEPTH),
        .BASE_ADDR   (BASE),
        .READ_LATENCY(LAT)
    ) dut (
        .G_clk  (G_clk),
        .G_reset(G_reset),
        .ARADDR (ARADDR),
        .ARLEN  (ARLEN),
        .ARSIZE (ARSIZE),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    initial G_clk = 1'b0;
    always #5 G_clk = ~G_clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] first_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beats from the burst rules: address sequence, then legality and range.
    task automatic build_model(input logic [31:0] addr, input int len, input int size, input int burst);
        logic [31:0] a;
        logic [31:0] idx;
        logic [31:0] step;
        logic [31:0] blk;
        logic [31:0] blk_base;
        bit          whole_err;
        bit          err;
        beat_t       b;
        exp_q.delete();
        step = 32'd1 << size;
        whole_err = (size > 2) || (burst == 3) ||
                    ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
                    ((burst == 2) && ((addr % step) != 0));
        a = addr;
        for (int i = 0; i <= len; i++) begin
            idx = (a - BASE) / 4;
            err = whole_err || (a < BASE) || (idx >= DEPTH);
            b.data = err ? 32'h0 : {16'hA5A5, idx[15:0]};
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            exp_q.push_back(b);
            if (burst == 1) begin
                a = a + step;
            end else if (burst == 2) begin
                blk      = (len + 1) * step;
                blk_base = a - (a % blk);
                a        = blk_base + ((a - blk_base + step) % blk);
            end
        end
    endtask

    // mode: 0 random RREADY, 1 RREADY held high, 2 toggling starting high.
    // abort_at >= 0 asserts reset once that many beats have been accepted.
    task automatic do_burst(input logic [31:0] addr, input int len, input int size,
                            input int burst, input int mode, input int abort_at);
        bit   got;
        int   n;
        int   idx;
        int   cyc;
        bit   rr;
        bit   vld;
        build_model(addr, len, size, burst);
        ARADDR  = addr;
        ARLEN   = 4'(len);
        ARSIZE  = 3'(size);
        ARBURST = 2'(burst);
        ARVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ARREADY) got = 1'b1;
            @(posedge G_clk); #1;
        end
        chk("ar_accept", 64'(got), 64'd1);
        ARVALID = 1'b0;
        chk("arready_after_accept", 64'(ARREADY), 64'd0);
        n = 0;
        while (!RVALID && n < 40) begin
            @(posedge G_clk); #1;
            n++;
        end
        chk("first_rvalid_latency", 64'(n), 64'(LAT + 1));
        idx = 0;
        cyc = 0;
        while (idx <= len && cyc < 200) begin
            if (idx == abort_at) begin
                G_reset = 1'b0;
                #1;
                chk("rst_rvalid", 64'(RVALID), 64'd0);
                chk("rst_arready", 64'(ARREADY), 64'd0);
                chk("rst_rlast", 64'(RLAST), 64'd0);
                RREADY = 1'b0;
                return;
            end
            vld = RVALID;
            chk("rvalid_in_burst", 64'(vld), 64'd1);
            chk("arready_busy", 64'(ARREADY), 64'd0);
            if (vld) begin
                chk("rdata", 64'(RDATA), 64'(exp_q[idx].data));
                chk("rresp", 64'(RRESP), 64'(exp_q[idx].resp));
                chk("rlast", 64'(RLAST), 64'(exp_q[idx].last));
                if (idx == 0) first_data = RDATA;
            end
            case (mode)
                1:       rr = 1'b1;
                2:       rr = (cyc % 2) == 0;
                default: rr = (cyc > 100) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            RREADY = rr;
            @(posedge G_clk); #1;
            if (rr && vld) idx++;
            cyc++;
        end
        RREADY = 1'b0;
        chk("beat_count", 64'(idx), 64'(len + 1));
        chk("rvalid_after_last", 64'(RVALID), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        first_data = '0;
        G_reset    = 1'b0;
        ARADDR     = '0;
        ARLEN      = '0;
        ARSIZE     = '0;
        ARBURST    = '0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;

        // Reset values and ARREADY rise one edge after release.
        repeat (3) @(posedge G_clk);
        #1;
        chk("reset_arready", 64'(ARREADY), 64'd0);
        chk("reset_rvalid", 64'(RVALID), 64'd0);
        chk("reset_rlast", 64'(RLAST), 64'd0);
        chk("reset_rresp", 64'(RRESP), 64'd0);
        chk("reset_rdata", 64'(RDATA), 64'd0);
        G_reset = 1'b1;
        #1;
        chk("arready_before_edge", 64'(ARREADY), 64'd0);
        @(posedge G_clk); #1;
        chk("arready_after_release", 64'(ARREADY), 64'd1);
        chk("rvalid_after_release", 64'(RVALID), 64'd0);

        // Single beat.
        do_burst(32'h8, 0, 2, 1, 1, -1);
        chk("single_beat_data", 64'(first_data), 64'h0000_0000_A5A5_0002);

        // INCR with stalls, WRAP order, FIXED repeat.
        do_burst(32'h4, 3, 2, 1, 2, -1);
        do_burst(32'h18, 3, 2, 2, 1, -1);
        chk("wrap_first_word", 64'(first_data), 64'h0000_0000_A5A5_0006);
        do_burst(32'hC, 2, 2, 0, 2, -1);

        // Range and legality errors.
        do_burst(32'hFC, 1, 2, 1, 1, -1);
        do_burst(32'h10, 1, 2, 3, 0, -1);
        do_burst(32'h10, 2, 2, 2, 0, -1);
        do_burst(32'h1A, 3, 2, 2, 0, -1);
        do_burst(32'h20, 1, 3, 1, 0, -1);
        do_burst(32'hFFFF_FFF8, 3, 2, 1, 0, -1);
        do_burst(32'h0, 15, 0, 2, 0, -1);
        do_burst(32'h3, 3, 0, 1, 0, -1);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            do_burst(32'($urandom_range(0, 32'h120)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, -1);
        end

        // Reset mid-burst, then a clean burst.
        do_burst(32'h0, 7, 2, 1, 1, 2);
        @(posedge G_clk); #1;
        chk("held_reset_rvalid", 64'(RVALID), 64'd0);
        G_reset = 1'b1;
        @(posedge G_clk); #1;
        chk("post_reset_arready", 64'(ARREADY), 64'd1);
        do_burst(32'h20, 3, 2, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
